// File: rtl/lca_pkg.sv
// Shared op encoding and per-beat op flags for the pipelined lookahead add/sub unit.
package lca_pkg;

    localparam logic [1:0] OP_ADD     = 2'b00;
    localparam logic [1:0] OP_SUB     = 2'b01;
    localparam int         OP_SAT_BIT = 1;

    typedef struct packed {
        logic sub;
        logic sat;
    } lca_op_t;

    function automatic lca_op_t decode_op(input logic [1:0] op);
        lca_op_t d;
        d.sub = ((op & OP_SUB) != OP_ADD);
        d.sat = op[OP_SAT_BIT];
        return d;
    endfunction

endpackage

// File: rtl/lca_group.sv
// Combinational BLOCK-bit carry-lookahead group: every bit carry is formed
// directly from prefix generate/propagate terms and the group carry-in.
module lca_group #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] i_a,
    input  logic [BLOCK-1:0] i_b,
    input  logic             i_cin,
    output logic [BLOCK-1:0] o_sum,
    output logic             o_cout,
    output logic             o_msb_carry_in
);

    logic [BLOCK-1:0] w_g;
    logic [BLOCK-1:0] w_p;
    logic [BLOCK:0]   w_c;
    logic             w_gg;
    logic             w_pp;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // w_gg / w_pp are the running group G[i:0] / P[i:0] prefixes.
    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        w_gg   = 1'b0;
        w_pp   = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            w_gg       = w_g[i] | (w_p[i] & w_gg);
            w_pp       = w_pp & w_p[i];
            w_c[i + 1] = w_gg | (w_pp & i_cin);
        end
    end

    assign o_sum          = w_p ^ w_c[BLOCK-1:0];
    assign o_cout         = w_c[BLOCK];
    assign o_msb_carry_in = w_c[BLOCK-1];

endmodule

// File: rtl/lca_pipe_addsub.sv
// Pipelined add/sub: one lookahead group resolved per stage, carry rippled between stages.
// Optional signed saturation in the final stage is enabled by defining LCA_SAT_EN.
module lca_pipe_addsub
    import lca_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BLOCK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [1:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf
);

    localparam int NSTG = WIDTH / BLOCK;

    // a_hi/b_hi carry the not-yet-consumed operand slices, sum_lo the resolved ones;
    // cin is the carry out of the group this stage just resolved.
    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
        logic             cin;
        logic             ovf;
        lca_op_t          op;
    } stg_t;

    stg_t r_stg [NSTG];
    stg_t w_nxt [NSTG];
    stg_t w_fin;

    logic                        w_adv;
    lca_op_t                     w_op;
    logic [WIDTH-1:0]            w_bx;
    logic                        w_cx;
    logic [NSTG-1:0][BLOCK-1:0]  w_ga;
    logic [NSTG-1:0][BLOCK-1:0]  w_gb;
    logic [NSTG-1:0][BLOCK-1:0]  w_gsum;
    logic [NSTG-1:0]             w_gc;
    logic [NSTG-1:0]             w_gcout;
    logic [NSTG-1:0]             w_gmc;

    assign w_adv    = !r_stg[NSTG-1].valid || out_ready;
    assign in_ready = w_adv;

    // Subtract is folded in once at the input so every group is a plain adder.
    assign w_op = decode_op(in_op);
    assign w_bx = w_op.sub ? ~in_b : in_b;
    assign w_cx = w_op.sub ? ~in_cin : in_cin;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        stg_t w_n;

        if (k == 0) begin : g_head
            assign w_ga[k] = in_a[BLOCK-1:0];
            assign w_gb[k] = w_bx[BLOCK-1:0];
            assign w_gc[k] = w_cx;

            always_comb begin
                w_n                     = '0;
                w_n.valid               = in_valid;
                w_n.a_hi                = in_a;
                w_n.b_hi                = w_bx;
                w_n.sum_lo[BLOCK-1:0]   = w_gsum[k];
                w_n.cin                 = w_gcout[k];
                w_n.ovf                 = w_gmc[k] ^ w_gcout[k];
                w_n.op                  = w_op;
            end
        end else begin : g_tail
            assign w_ga[k] = r_stg[k-1].a_hi[k*BLOCK +: BLOCK];
            assign w_gb[k] = r_stg[k-1].b_hi[k*BLOCK +: BLOCK];
            assign w_gc[k] = r_stg[k-1].cin;

            always_comb begin
                w_n                            = r_stg[k-1];
                w_n.sum_lo[k*BLOCK +: BLOCK]   = w_gsum[k];
                w_n.cin                        = w_gcout[k];
                w_n.ovf                        = w_gmc[k] ^ w_gcout[k];
            end
        end

        lca_group #(.BLOCK(BLOCK)) u_grp (
            .i_a            (w_ga[k]),
            .i_b            (w_gb[k]),
            .i_cin          (w_gc[k]),
            .o_sum          (w_gsum[k]),
            .o_cout         (w_gcout[k]),
            .o_msb_carry_in (w_gmc[k])
        );

        assign w_nxt[k] = w_n;
    end

    always_comb begin
        w_fin = w_nxt[NSTG-1];
`ifdef LCA_SAT_EN
        // Raw MSB set on overflow means the true result was positive.
        if (w_fin.op.sat && w_fin.ovf) begin
            w_fin.sum_lo = w_fin.sum_lo[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                                 : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                r_stg[k] <= '0;
            end
        end else if (w_adv) begin
            for (int k = 0; k < NSTG - 1; k++) begin
                r_stg[k] <= w_nxt[k];
            end
            r_stg[NSTG-1] <= w_fin;
        end
    end

    assign out_valid = r_stg[NSTG-1].valid;
    assign out_sum   = r_stg[NSTG-1].sum_lo;
    assign out_cout  = r_stg[NSTG-1].cin;
    assign out_ovf   = r_stg[NSTG-1].ovf;

endmodule

// File: tb/tb_lca_pipe_addsub.sv
// Bench for lca_pipe_addsub (WIDTH=32, BLOCK=8): directed table, stall/reset sequences, random stream.
module tb_lca_pipe_addsub;

    localparam int WIDTH = 32;
    localparam int BLOCK = 8;
    localparam int NSTG  = WIDTH / BLOCK;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    lca_pipe_addsub #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    int   n_pass = 0;
    int   n_tot  = 0;
    int   n_emit = 0;
    res_t q[$];
    res_t held;
    logic held_v = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    // Reference: wide unsigned sum for carry, wide signed sum for overflow.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic cin);
        logic [31:0] bx;
        logic        cx;
        logic [63:0] u;
        longint      s;
        res_t        r;
        bx     = op[0] ? ~b : b;
        cx     = op[0] ? ~cin : cin;
        u      = 64'(a) + 64'(bx) + 64'(cx);
        s      = longint'($signed(a)) + longint'($signed(bx)) + longint'(cx);
        r.sum  = u[31:0];
        r.cout = u[32];
        r.ovf  = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
`ifdef LCA_SAT_EN
        if (op[1] && r.ovf) r.sum = (s > 0) ? 32'h7FFFFFFF : 32'h80000000;
`endif
        return r;
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return 32'h00000000;
            default: return $urandom;
        endcase
    endfunction

    // One cycle, entered just after a negedge: drive, check the output side, log accepts.
    task automatic step(input logic v, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input logic ordy,
                        output logic acc);
        res_t e;
        out_ready = ordy;
        in_valid  = v;
        in_op     = op;
        in_a      = a;
        in_b      = b;
        in_cin    = cin;
        #1;
        chk("in_ready", in_ready, !out_valid || out_ready);
        if (out_valid) begin
            if (held_v) begin
                chk("stall.sum",  out_sum,  held.sum);
                chk("stall.cout", out_cout, held.cout);
                chk("stall.ovf",  out_ovf,  held.ovf);
            end
            if (out_ready) begin
                held_v = 1'b0;
                n_emit++;
                if (q.size() == 0) begin
                    chk("spurious_emit", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb.sum",  out_sum,  e.sum);
                    chk("sb.cout", out_cout, e.cout);
                    chk("sb.ovf",  out_ovf,  e.ovf);
                end
            end else begin
                held.sum  = out_sum;
                held.cout = out_cout;
                held.ovf  = out_ovf;
                held_v    = 1'b1;
            end
        end else begin
            held_v = 1'b0;
        end
        acc = v && in_ready;
        if (acc) q.push_back(model(op, a, b, cin));
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tv[$];
        int          lat;
        int          sent;
        int          cyc;
        int          acc_cnt;
        logic        acc;
        logic [1:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;

        tv.push_back('{"add_wrap",  2'b00, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0});
        tv.push_back('{"sub_neg",   2'b01, 32'h00000005, 32'h00000007, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0});
        tv.push_back('{"sub_bin",   2'b01, 32'h00000007, 32'h00000005, 1'b1, 32'h00000001, 1'b1, 1'b0});
        tv.push_back('{"add_ovf",   2'b00, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
`ifdef LCA_SAT_EN
        tv.push_back('{"add_sat",   2'b10, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1});
        tv.push_back('{"sub_sat",   2'b11, 32'h80000000, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 1'b1});
`else
        tv.push_back('{"add_sat",   2'b10, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1});
        tv.push_back('{"sub_sat",   2'b11, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1});
`endif
        tv.push_back('{"ripple",    2'b00, 32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0, 1'b0});
        tv.push_back('{"sub_zero",  2'b01, 32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b1, 1'b0});
        tv.push_back('{"add_negov", 2'b00, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        in_op     = 2'b00;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_sum",   out_sum,   0);
        chk("rst.out_cout",  out_cout,  0);
        chk("rst.out_ovf",   out_ovf,   0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst.in_ready", in_ready, 1);

        // Directed vectors, one at a time, with latency measured in cycles.
        out_ready = 1'b1;
        foreach (tv[i]) begin
            in_op    = tv[i].op;
            in_a     = tv[i].a;
            in_b     = tv[i].b;
            in_cin   = tv[i].cin;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            lat = 1;
            while (!out_valid && lat < 20) begin
                @(negedge clk);
                lat++;
            end
            chk($sformatf("%s.latency", tv[i].name), lat,      NSTG);
            chk($sformatf("%s.sum",     tv[i].name), out_sum,  tv[i].sum);
            chk($sformatf("%s.cout",    tv[i].name), out_cout, tv[i].cout);
            chk($sformatf("%s.ovf",     tv[i].name), out_ovf,  tv[i].ovf);
            @(negedge clk);
        end

        // Six back-to-back beats with a three-cycle output stall mid-stream.
        n_emit = 0;
        sent   = 0;
        cyc    = 0;
        while ((sent < 6 || q.size() > 0) && cyc < 60) begin
            op = 2'($urandom_range(0, 3));
            ra = rnd_val();
            rb = rnd_val();
            step(sent < 6, op, ra, rb, 1'($urandom), !(cyc >= 5 && cyc <= 7), acc);
            if (acc) sent++;
            cyc++;
        end
        chk("stall.timeout", cyc < 60, 1);
        chk("stall.emitted", n_emit, 6);

        // Reset with three beats in flight: none of them may surface.
        held_v = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2'b00, 32'h11111111 * (i + 1), 32'h01010101, 1'b0, 1'b1, acc);
        end
        rst      = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.out_sum",   out_sum,   0);
        chk("midrst.out_cout",  out_cout,  0);
        chk("midrst.out_ovf",   out_ovf,   0);
        rst = 1'b0;
        #1;
        chk("midrst.in_ready", in_ready, 1);
        q.delete();
        n_emit = 0;
        for (int i = 0; i < 8; i++) step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, acc);
        chk("midrst.no_emit", n_emit, 0);

        // 100 random ops streamed with the output always ready.
        n_emit  = 0;
        acc_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            op = 2'($urandom_range(0, 3));
            ra = rnd_val();
            rb = rnd_val();
            step(1'b1, op, ra, rb, 1'($urandom), 1'b1, acc);
            if (acc) acc_cnt++;
        end
        chk("rand.accepted",   acc_cnt, 100);
        chk("rand.throughput", n_emit,  100 - NSTG);
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            step(1'b0, 2'b00, '0, '0, 1'b0, 1'b1, acc);
            cyc++;
        end
        chk("rand.emitted", n_emit,   100);
        chk("rand.drained", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
